// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/IO responder: MMIO register offsets,
// FSM state encoding and STAT register bit positions.
package mem_io_pkg;

  localparam int unsigned OFF_BTN   = 0;
  localparam int unsigned OFF_ACCEL = 1;
  localparam int unsigned OFF_STAT  = 2;
  localparam int unsigned OFF_LED   = 3;
  localparam int unsigned OFF_TICK  = 4;

  localparam int unsigned STAT_ACCEL_NEW = 0;
  localparam int unsigned STAT_BTN_ANY   = 1;
  localparam int unsigned STAT_ERR       = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAM_RD = 2'd1,
    S_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU data-memory bus: request/ack handshake between the multicycle CPU
// (master) and the memory/IO responder (slave).
interface mem_io_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  ack, rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_io_responder_btn_edge_latch.sv
// Button front end: 2-FF synchronizer, rising-edge detect and a sticky bit
// per button that is cleared by a BTN register read.
module btn_edge_latch #(
  parameter int NBTN = 4
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [NBTN-1:0] btn_i,
  input  logic            clear_i,
  output logic [NBTN-1:0] sticky_o
);

  logic [NBTN-1:0] sync1_q, sync2_q, prev_q, sticky_q, sticky_d, rise;

  assign rise = sync2_q & ~prev_q;

  // An edge arriving in the same cycle as a read-clear must survive the clear.
  assign sticky_d = (clear_i ? '0 : sticky_q) | rise;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      sticky_q <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;

endmodule

// File: rtl/mem_io_responder.sv
// Memory/IO responder: decodes CPU loads/stores to block RAM or MMIO registers
// and acks each one. Define MEM_IO_TIMER_EN to add the TICK cycle counter at +4.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 16,
  parameter int                RAM_LAT = 1,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(16'hFF00),
  parameter int                NBTN    = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  mem_io_responder_if.slave   bus,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic                ram_we_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i,
  input  logic [NBTN-1:0]     btn_in_i,
  input  logic                accel_valid_i,
  input  logic [DATA_W-1:0]   accel_data_i,
  output logic [DATA_W-1:0]   led_out_o
);

  localparam logic [1:0] LAT_INIT = 2'(RAM_LAT);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              hold_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [DATA_W-1:0] accel_q;
  logic              accel_new_q, accel_new_d;
  logic              err_q, err_d;
  logic              ack_c, btn_clr, is_io;
  logic [ADDR_W-1:0] io_off;
  logic [NBTN-1:0]   btn_sticky;
  logic [DATA_W-1:0] stat_word;

  btn_edge_latch #(.NBTN(NBTN)) u_btn (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .btn_i    (btn_in_i),
    .clear_i  (btn_clr),
    .sticky_o (btn_sticky)
  );

  assign is_io  = (bus.req_addr >= IO_BASE);
  assign io_off = bus.req_addr - IO_BASE;

  always_comb begin
    stat_word                 = '0;
    stat_word[STAT_ERR]       = err_q;
    stat_word[STAT_BTN_ANY]   = |btn_sticky;
    stat_word[STAT_ACCEL_NEW] = accel_new_q;
  end

`ifdef MEM_IO_TIMER_EN
  logic [15:0] tick_q;
  logic        tick_clr;

  always_ff @(posedge clock_i) begin
    if (reset_i || tick_clr) tick_q <= 16'd0;
    else                     tick_q <= tick_q + 16'd1;
  end
`endif

  // hold_q blocks the IDLE cycle right after RESP so a still-high req_valid
  // is not taken as a second request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    led_d       = led_q;
    err_d       = err_q;
    accel_new_d = accel_new_q;
    ack_c       = 1'b0;
    btn_clr     = 1'b0;
`ifdef MEM_IO_TIMER_EN
    tick_clr    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !hold_q) begin
          if (is_io) begin
            state_d = S_RESP;
            case (io_off)
              ADDR_W'(OFF_BTN): begin
                if (!bus.req_we) begin
                  rdata_d = DATA_W'(btn_sticky);
                  btn_clr = 1'b1;
                end
              end
              ADDR_W'(OFF_ACCEL): begin
                if (!bus.req_we) begin
                  rdata_d     = accel_q;
                  accel_new_d = 1'b0;
                end
              end
              ADDR_W'(OFF_STAT): begin
                if (!bus.req_we) begin
                  rdata_d = stat_word;
                  err_d   = 1'b0;
                end
              end
              ADDR_W'(OFF_LED): begin
                if (bus.req_we) led_d   = bus.req_wdata;
                else            rdata_d = led_q;
              end
`ifdef MEM_IO_TIMER_EN
              ADDR_W'(OFF_TICK): begin
                if (bus.req_we) tick_clr = 1'b1;
                else            rdata_d  = DATA_W'(tick_q);
              end
`endif
              default: begin
                if (!bus.req_we) rdata_d = '0;
                err_d = 1'b1;
              end
            endcase
          end else if (bus.req_we) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = bus.req_addr;
            ram_wdata_d = bus.req_wdata;
            state_d     = S_RESP;
          end else begin
            ram_addr_d = bus.req_addr;
            cnt_d      = LAT_INIT;
            state_d    = S_RAM_RD;
          end
        end
      end
      S_RAM_RD: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          rdata_d = ram_rdata_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ack_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A fresh sample wins over an ACCEL read clearing the flag.
    if (accel_valid_i) accel_new_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= 1'b0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      led_q       <= '0;
      accel_q     <= '0;
      accel_new_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= (state_q == S_RESP);
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      led_q       <= led_d;
      accel_new_q <= accel_new_d;
      err_q       <= err_d;
      if (accel_valid_i) accel_q <= accel_data_i;
    end
  end

  assign bus.ack     = ack_c;
  assign bus.rdata   = rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_wdata_o = ram_wdata_q;
  assign led_out_o   = led_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM store/load, MMIO registers, err
// reporting, held-request blocking and reset abort, against hand-computed values.
module tb_mem_io_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] ramAddr;
  logic        ramWe;
  logic [15:0] ramWdata;
  logic [15:0] ramRdata;
  logic [3:0]  btnIn;
  logic        accelValid;
  logic [15:0] accelData;
  logic [15:0] ledOut;

  int vecCount  = 0;
  int missCount = 0;
  int ackCount  = 0;
  int weCount   = 0;

  logic [15:0] rd;
  int          lat;

  always #5 clock = ~clock;

  mem_io_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_io_responder #(
    .DATA_W(16), .ADDR_W(16), .RAM_LAT(1), .IO_BASE(16'hFF00), .NBTN(4)
  ) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .bus           (bus),
    .ram_addr_o    (ramAddr),
    .ram_we_o      (ramWe),
    .ram_wdata_o   (ramWdata),
    .ram_rdata_i   (ramRdata),
    .btn_in_i      (btnIn),
    .accel_valid_i (accelValid),
    .accel_data_i  (accelData),
    .led_out_o     (ledOut)
  );

  // Block RAM model: the responder's address register is the BRAM address
  // register, so with one cycle of latency the data follows ram_addr directly.
  logic [15:0] mem [0:255];
  always @(posedge clock) if (ramWe) mem[ramAddr[7:0]] <= ramWdata;
  assign ramRdata = mem[ramAddr[7:0]];

  // Count ack pulses and RAM write strobes, sampled away from the active edge.
  always @(negedge clock) begin
    if (bus.ack) ackCount++;
    if (ramWe)   weCount++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus transaction; lat is the cycle (request cycle = 1) in which ack
  // was seen, or 0 if no ack came within the budget.
  task automatic applyStimulus(input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata,
                               output logic [15:0] rdOut, output int latOut);
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    latOut = 0;
    rdOut  = 16'hxxxx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (bus.ack) begin
        latOut = c;
        rdOut  = bus.rdata;
        break;
      end
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    vecCount++; if (bus.ack !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ack got %b expected 0", bus.ack); end
    vecCount++; if (bus.rdata !== 16'h0000) begin missCount++; $display("[TB] FAIL reset_rdata got %h expected 0000", bus.rdata); end
    vecCount++; if (ramWe !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ram_we got %b expected 0", ramWe); end
    vecCount++; if (ramAddr !== 16'h0000) begin missCount++; $display("[TB] FAIL reset_ram_addr got %h expected 0000", ramAddr); end
    vecCount++; if (ramWdata !== 16'h0000) begin missCount++; $display("[TB] FAIL reset_ram_wdata got %h expected 0000", ramWdata); end
    vecCount++; if (ledOut !== 16'h0000) begin missCount++; $display("[TB] FAIL reset_led got %h expected 0000", ledOut); end
  endtask

  task automatic test_ram();
    int weBefore;
    weBefore = weCount;
    applyStimulus(1'b1, 16'h0010, 16'h1234, rd, lat);
    vecCount++; if (lat != 2) begin missCount++; $display("[TB] FAIL store_latency got %0d expected 2", lat); end
    repeat (2) @(negedge clock);
    vecCount++; if (weCount - weBefore != 1) begin missCount++; $display("[TB] FAIL store_we_pulses got %0d expected 1", weCount - weBefore); end
    applyStimulus(1'b0, 16'h0010, 16'h0000, rd, lat);
    vecCount++; if (lat != 3) begin missCount++; $display("[TB] FAIL load_latency got %0d expected 3", lat); end
    vecCount++; if (rd !== 16'h1234) begin missCount++; $display("[TB] FAIL load_0010 got %h expected 1234", rd); end
    applyStimulus(1'b1, 16'h0011, 16'hABCD, rd, lat);
    applyStimulus(1'b0, 16'h0011, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'hABCD) begin missCount++; $display("[TB] FAIL load_0011 got %h expected abcd", rd); end
    applyStimulus(1'b0, 16'h0010, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h1234) begin missCount++; $display("[TB] FAIL reload_0010 got %h expected 1234", rd); end
  endtask

  task automatic test_led();
    applyStimulus(1'b1, 16'hFF03, 16'h5A5A, rd, lat);
    vecCount++; if (lat != 2) begin missCount++; $display("[TB] FAIL mmio_latency got %0d expected 2", lat); end
    vecCount++; if (ledOut !== 16'h5A5A) begin missCount++; $display("[TB] FAIL led_out got %h expected 5a5a", ledOut); end
    applyStimulus(1'b0, 16'hFF03, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h5A5A) begin missCount++; $display("[TB] FAIL led_read got %h expected 5a5a", rd); end
  endtask

  task automatic test_btn();
    @(posedge clock); #1 btnIn[2] = 1'b1;
    repeat (5) @(posedge clock);
    applyStimulus(1'b0, 16'hFF00, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0004) begin missCount++; $display("[TB] FAIL btn_first_read got %h expected 0004", rd); end
    applyStimulus(1'b0, 16'hFF00, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0000) begin missCount++; $display("[TB] FAIL btn_second_read got %h expected 0000", rd); end
    @(posedge clock); #1 btnIn[0] = 1'b1;
    repeat (5) @(posedge clock);
    applyStimulus(1'b1, 16'hFF00, 16'hFFFF, rd, lat);
    applyStimulus(1'b0, 16'hFF02, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0002) begin missCount++; $display("[TB] FAIL btn_stat got %h expected 0002", rd); end
    applyStimulus(1'b0, 16'hFF00, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0001) begin missCount++; $display("[TB] FAIL btn_after_write got %h expected 0001", rd); end
  endtask

  task automatic test_accel();
    @(posedge clock); #1;
    accelValid = 1'b1;
    accelData  = 16'hBEEF;
    @(posedge clock); #1;
    accelValid = 1'b0;
    accelData  = 16'h0000;
    applyStimulus(1'b0, 16'hFF02, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0001) begin missCount++; $display("[TB] FAIL accel_stat_new got %h expected 0001", rd); end
    applyStimulus(1'b0, 16'hFF01, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'hBEEF) begin missCount++; $display("[TB] FAIL accel_read got %h expected beef", rd); end
    applyStimulus(1'b0, 16'hFF02, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0000) begin missCount++; $display("[TB] FAIL accel_stat_clear got %h expected 0000", rd); end
  endtask

  task automatic test_unmapped();
    applyStimulus(1'b0, 16'hFF03, 16'h0000, rd, lat);
    applyStimulus(1'b0, 16'hFF20, 16'h0000, rd, lat);
    vecCount++; if (lat != 2) begin missCount++; $display("[TB] FAIL unmapped_latency got %0d expected 2", lat); end
    vecCount++; if (rd !== 16'h0000) begin missCount++; $display("[TB] FAIL unmapped_read got %h expected 0000", rd); end
    applyStimulus(1'b0, 16'hFF02, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0004) begin missCount++; $display("[TB] FAIL unmapped_err_set got %h expected 0004", rd); end
    applyStimulus(1'b0, 16'hFF02, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0000) begin missCount++; $display("[TB] FAIL unmapped_err_clear got %h expected 0000", rd); end
  endtask

  task automatic test_tick();
`ifdef MEM_IO_TIMER_EN
    applyStimulus(1'b1, 16'hFF04, 16'hDEAD, rd, lat);
    repeat (9) @(posedge clock);
    applyStimulus(1'b0, 16'hFF04, 16'h0000, rd, lat);
    vecCount++; if ($isunknown(rd) || rd < 16'd10 || rd > 16'd12) begin missCount++; $display("[TB] FAIL tick_read got %0d expected 10..12", rd); end
    applyStimulus(1'b0, 16'hFF02, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0000) begin missCount++; $display("[TB] FAIL tick_no_err got %h expected 0000", rd); end
`else
    applyStimulus(1'b0, 16'hFF03, 16'h0000, rd, lat);
    applyStimulus(1'b0, 16'hFF04, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0000) begin missCount++; $display("[TB] FAIL tick_unmapped got %h expected 0000", rd); end
    applyStimulus(1'b0, 16'hFF02, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h0004) begin missCount++; $display("[TB] FAIL tick_err got %h expected 0004", rd); end
`endif
  endtask

  task automatic test_back_to_back();
    int ackBefore, weBefore;
    ackBefore = ackCount;
    weBefore  = weCount;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0030;
    bus.req_wdata = 16'h4242;
    repeat (3) @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    repeat (4) @(negedge clock);
    vecCount++; if (ackCount - ackBefore != 1) begin missCount++; $display("[TB] FAIL held_req_acks got %0d expected 1", ackCount - ackBefore); end
    vecCount++; if (weCount - weBefore != 1) begin missCount++; $display("[TB] FAIL held_req_writes got %0d expected 1", weCount - weBefore); end
    applyStimulus(1'b0, 16'h0030, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'h4242) begin missCount++; $display("[TB] FAIL b2b_load_0030 got %h expected 4242", rd); end
    applyStimulus(1'b0, 16'h0011, 16'h0000, rd, lat);
    vecCount++; if (rd !== 16'hABCD) begin missCount++; $display("[TB] FAIL b2b_load_0011 got %h expected abcd", rd); end
  endtask

  task automatic test_reset_abort();
    int ackBefore, weBefore;
    applyStimulus(1'b1, 16'hFF03, 16'h00FF, rd, lat);
    vecCount++; if (ledOut !== 16'h00FF) begin missCount++; $display("[TB] FAIL abort_led_pre got %h expected 00ff", ledOut); end
    ackBefore = ackCount;
    weBefore  = weCount;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0010;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 bus.req_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    vecCount++; if (ackCount != ackBefore) begin missCount++; $display("[TB] FAIL abort_load_ack got %0d expected 0", ackCount - ackBefore); end
    vecCount++; if (ramWe !== 1'b0) begin missCount++; $display("[TB] FAIL abort_ram_we got %b expected 0", ramWe); end
    vecCount++; if (ledOut !== 16'h0000) begin missCount++; $display("[TB] FAIL abort_led got %h expected 0000", ledOut); end
    vecCount++; if (bus.rdata !== 16'h0000) begin missCount++; $display("[TB] FAIL abort_rdata got %h expected 0000", bus.rdata); end
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0010;
    bus.req_wdata = 16'hDEAD;
    reset         = 1'b1;
    @(posedge clock); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    repeat (3) @(negedge clock);
    vecCount++; if (weCount != weBefore) begin missCount++; $display("[TB] FAIL abort_store_writes got %0d expected 0", weCount - weBefore); end
    vecCount++; if (ackCount != ackBefore) begin missCount++; $display("[TB] FAIL abort_store_ack got %0d expected 0", ackCount - ackBefore); end
    applyStimulus(1'b0, 16'h0010, 16'h0000, rd, lat);
    vecCount++; if (lat != 3) begin missCount++; $display("[TB] FAIL post_abort_latency got %0d expected 3", lat); end
    vecCount++; if (rd !== 16'h1234) begin missCount++; $display("[TB] FAIL post_abort_load got %h expected 1234", rd); end
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;
    btnIn         = 4'b0000;
    accelValid    = 1'b0;
    accelData     = 16'h0000;
    $display("[TB] starting mem_io_responder directed tests");
    test_reset();
    test_ram();
    test_led();
    test_btn();
    test_accel();
    test_unmapped();
    test_tick();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
